conv_window_gen: RTL



---
 rtl/conv_window_gen.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster pixel stream to padded, dilated KERNEL_0 x KERNEL_1 window generator
module conv_window_gen #(
  parameter int IN_WIDTH   = 513,
  parameter int IN_HEIGHT  = 257,
  parameter int IN_CHANNEL = 3,
  parameter int KERNEL_0   = 3,
  parameter int KERNEL_1   = 3,
  parameter int DILATION_0 = 2,
  parameter int DILATION_1 = 2,
  parameter int PADDING_0  = 2,
  parameter int PADDING_1  = 2,
  parameter int STRIDE_0   = 1,
  parameter int STRIDE_1   = 1,
  parameter int PAD_VALUE  = 128
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [8*IN_CHANNEL-1:0]                   i_data,
  input  logic                                      i_valid,
  output logic                                      i_ready,
  output logic [8*IN_CHANNEL*KERNEL_0*KERNEL_1-1:0] o_data,
  output logic                                      o_valid,
  input  logic                                      pe_ack,
  output logic                                      o_frame_last
);

  localparam int PH     = IN_HEIGHT + 2*PADDING_0;
  localparam int PW     = IN_WIDTH + 2*PADDING_1;
  localparam int EK0    = DILATION_0*(KERNEL_0-1) + 1;
  localparam int EK1    = DILATION_1*(KERNEL_1-1) + 1;
  localparam int OH     = (PH - EK0)/STRIDE_0 + 1;
  localparam int OW     = (PW - EK1)/STRIDE_1 + 1;
  localparam int LAST_R = EK0 - 1 + (OH-1)*STRIDE_0;
  localparam int LAST_C = EK1 - 1 + (OW-1)*STRIDE_1;
  localparam int PRW    = (PH > 1) ? $clog2(PH) : 1;
  localparam int PCW    = (PW > 1) ? $clog2(PW) : 1;
  localparam int S0W    = (STRIDE_0 > 1) ? $clog2(STRIDE_0) : 1;
  localparam int S1W    = (STRIDE_1 > 1) ? $clog2(STRIDE_1) : 1;
  localparam int LBR    = (EK0 > 1) ? EK0 - 1 : 1;
  localparam int LBW    = (LBR > 1) ? $clog2(LBR) : 1;
  localparam int PXW    = 8*IN_CHANNEL;
  localparam int COLW   = PXW*EK0;
  localparam int WINW   = PXW*KERNEL_0*KERNEL_1;
  localparam logic [7:0] PAD_B = 8'(PAD_VALUE);

  logic [PRW-1:0]     pr_q, pr_d;
  logic [PCW-1:0]     pc_q, pc_d;
  logic [S0W-1:0]     ph0_q, ph0_d;
  logic [S1W-1:0]     ph1_q, ph1_d;
  logic [LBW-1:0]     ptr_q, ptr_d;
  logic               o_valid_q, o_valid_d;
  logic               o_last_q, o_last_d;
  logic [WINW-1:0]    o_data_q, o_data_d;
  logic [PW*PXW-1:0]  lb_q [LBR];
  logic [PW*PXW-1:0]  lb_d [LBR];
  logic [EK1*COLW-1:0] col_q, col_d, colsh;
  logic [COLW-1:0]    newcol;
  logic [WINW-1:0]    win;
  logic [PXW-1:0]     pix;
  logic [LBW-1:0]     ridx;
  logic               is_pad, stall, adv, corner;

  // Classify the scan position, decide whether it advances, and assemble the window ending at it
  always_comb begin
    is_pad = (int'(pr_q) < PADDING_0) || (int'(pr_q) >= PADDING_0 + IN_HEIGHT) ||
             (int'(pc_q) < PADDING_1) || (int'(pc_q) >= PADDING_1 + IN_WIDTH);
    stall  = o_valid_q && !pe_ack;
    adv    = !stall && (is_pad || i_valid);
    corner = (int'(pr_q) >= EK0-1) && (int'(pc_q) >= EK1-1) && (ph0_q == '0) && (ph1_q == '0);
    pix    = is_pad ? {IN_CHANNEL{PAD_B}} : i_data;
    // ring slot ptr_q holds the oldest buffered row; following slots hold successively newer rows
    newcol = '0;
    ridx   = '0;
    for (int i = 0; i < EK0-1; i++) begin
      ridx = LBW'((int'(ptr_q) + i) % LBR);
      newcol[i*PXW +: PXW] = lb_q[ridx][pc_q*PXW +: PXW];
    end
    newcol[(EK0-1)*PXW +: PXW] = pix;
    colsh = '0;
    for (int j = 0; j < EK1-1; j++) begin
      colsh[j*COLW +: COLW] = col_q[(j+1)*COLW +: COLW];
    end
    colsh[(EK1-1)*COLW +: COLW] = newcol;
    win = '0;
    for (int ky = 0; ky < KERNEL_0; ky++) begin
      for (int kx = 0; kx < KERNEL_1; kx++) begin
        win[(ky*KERNEL_1+kx)*PXW +: PXW] = colsh[kx*DILATION_1*COLW + ky*DILATION_0*PXW +: PXW];
      end
    end
  end

  // Next-state: scan counters, stride phases, ring pointer, buffers and the held output window
  always_comb begin
    pr_d      = pr_q;
    pc_d      = pc_q;
    ph0_d     = ph0_q;
    ph1_d     = ph1_q;
    ptr_d     = ptr_q;
    lb_d      = lb_q;
    col_d     = col_q;
    o_valid_d = o_valid_q;
    o_last_d  = o_last_q;
    o_data_d  = o_data_q;
    if (o_valid_q && pe_ack) begin
      o_valid_d = 1'b0;
      o_last_d  = 1'b0;
    end
    if (adv) begin
      lb_d[ptr_q][pc_q*PXW +: PXW] = pix;
      col_d = colsh;
      if (int'(pc_q) == PW-1) begin
        pc_d  = '0;
        ph1_d = '0;
        ptr_d = (int'(ptr_q) == LBR-1) ? '0 : ptr_q + 1'b1;
        if (int'(pr_q) == PH-1) begin
          pr_d  = '0;
          ph0_d = '0;
          ptr_d = '0;
        end else begin
          pr_d = pr_q + 1'b1;
          if (int'(pr_q) >= EK0-1) ph0_d = (int'(ph0_q) == STRIDE_0-1) ? '0 : ph0_q + 1'b1;
        end
      end else begin
        pc_d = pc_q + 1'b1;
        if (int'(pc_q) >= EK1-1) ph1_d = (int'(ph1_q) == STRIDE_1-1) ? '0 : ph1_q + 1'b1;
      end
      if (corner) begin
        o_valid_d = 1'b1;
        o_last_d  = (int'(pr_q) == LAST_R) && (int'(pc_q) == LAST_C);
        o_data_d  = win;
      end
    end
  end

  // Control state; reset abandons any partial frame and held window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_q      <= '0;
      pc_q      <= '0;
      ph0_q     <= '0;
      ph1_q     <= '0;
      ptr_q     <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else begin
      pr_q      <= pr_d;
      pc_q      <= pc_d;
      ph0_q     <= ph0_d;
      ph1_q     <= ph1_d;
      ptr_q     <= ptr_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
    end
  end

  // Data storage; contents are only read once rewritten by the current frame
  always_ff @(posedge clk) begin
    lb_q     <= lb_d;
    col_q    <= col_d;
    o_data_q <= o_data_d;
  end

  assign i_ready      = rst_n && !is_pad && !stall;
  assign o_valid      = o_valid_q;
  assign o_frame_last = o_last_q;
  assign o_data       = o_data_q;

endmodule
